// File: rtl/mem_responder_if.sv
// RAM-side bus of mem_responder: one single-port request/acknowledge channel.
// The responder is the master; the RAM (or its model) is the slave.
interface mem_responder_if #(
  parameter int ADDR_W = 18
);
  logic              ram_req;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_ack;
  logic [31:0]       ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Serializes a CPU access bundle (read0, read1, optional write) onto one RAM port.
// Optional feature: define MEM_RESPONDER_DEDUP_EN to skip a second read of the same address.
module mem_responder #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [31:0]       rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [31:0]       rdata1,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  output logic              clk_en,
  mem_responder_if.master   mem
);

  typedef enum logic [2:0] {
    CAPTURE,
    RD0,
    RD1,
    WR,
    RELEASE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] raddr1_p0;
  logic [3:0]        wen_p0;
  logic [ADDR_W-1:0] waddr_p0;
  logic [31:0]       wdata_p0;
  logic              skip_rd1;

  // Capture stage: bundle operands are data, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      raddr1_p0 <= raddr1;
      wen_p0    <= wen;
      waddr_p0  <= waddr;
      wdata_p0  <= wdata;
    end
  end

`ifdef MEM_RESPONDER_DEDUP_EN
  // Only consulted in RD0, where ram_addr still holds the latched raddr0.
  assign skip_rd1 = (raddr1_p0 == mem.ram_addr);
`else
  assign skip_rd1 = 1'b0;
`endif

  // Request stage: every bus output is a register, so a request is held
  // unchanged until the cycle in which ram_ack completes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= CAPTURE;
      clk_en        <= 1'b0;
      mem.ram_req   <= 1'b0;
      mem.ram_we    <= 4'd0;
      mem.ram_addr  <= '0;
      mem.ram_wdata <= 32'd0;
      rdata0        <= 32'd0;
      rdata1        <= 32'd0;
    end else begin
      case (state)
        CAPTURE: begin
          mem.ram_req  <= 1'b1;
          mem.ram_we   <= 4'd0;
          mem.ram_addr <= raddr0;
          state        <= RD0;
        end

        RD0, RD1: begin
          if (mem.ram_ack) begin
            if (state == RD0) rdata0 <= mem.ram_rdata;
            if (state == RD1 || skip_rd1) rdata1 <= mem.ram_rdata;

            if (state == RD0 && !skip_rd1) begin
              mem.ram_addr <= raddr1_p0;
              state        <= RD1;
            end else if (wen_p0 != 4'd0) begin
              mem.ram_we    <= wen_p0;
              mem.ram_addr  <= waddr_p0;
              mem.ram_wdata <= wdata_p0;
              state         <= WR;
            end else begin
              mem.ram_req <= 1'b0;
              clk_en      <= 1'b1;
              state       <= RELEASE;
            end
          end
        end

        WR: begin
          if (mem.ram_ack) begin
            mem.ram_req <= 1'b0;
            mem.ram_we  <= 4'd0;
            clk_en      <= 1'b1;
            state       <= RELEASE;
          end
        end

        RELEASE: begin
          clk_en <= 1'b0;
          state  <= CAPTURE;
        end

        default: begin
          mem.ram_req <= 1'b0;
          mem.ram_we  <= 4'd0;
          clk_en      <= 1'b0;
          state       <= CAPTURE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a behavioural RAM with programmable ack delay,
// a driver that issues bundles, and a monitor that checks requests and releases.
module tb_mem_responder;
  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] raddr0, raddr1, waddr;
  logic [31:0]       rdata0, rdata1, wdata;
  logic [3:0]        wen;
  logic              clk_en;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr0 (raddr0),
    .rdata0 (rdata0),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata),
    .clk_en (clk_en),
    .mem    (bus)
  );

  // Behavioural RAM: ack after 'delay' waiting cycles, write on the acked edge.
  logic [31:0] ram [0:255];
  int          delay = 0;
  int          wcnt;
  logic        init_done = 1'b0;

  assign bus.ram_ack   = bus.ram_req && (wcnt == delay);
  assign bus.ram_rdata = ram[bus.ram_addr[7:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      if (!init_done) begin
        for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
        ram[8'h10] <= 32'hAAAA0001;
        ram[8'h20] <= 32'hBBBB0002;
        ram[8'h50] <= 32'hCAFE0050;
        init_done  <= 1'b1;
      end
    end else if (bus.ram_req) begin
      if (bus.ram_ack) begin
        wcnt <= 0;
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) ram[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  typedef struct packed {
    logic [31:0]              rd0;
    logic [31:0]              rd1;
    logic [7:0]               lat;
    logic [7:0]               nreq;
    logic [2:0][3:0]          we;
    logic [2:0][ADDR_W-1:0]   addr;
    logic [2:0][31:0]         wd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected request sequence: read a0, read a1 (unless deduplicated), then the write if any.
  function automatic exp_t mk(input logic [31:0] rd0, input logic [31:0] rd1, input int lat,
                              input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                              input logic [3:0] w, input logic [ADDR_W-1:0] wa,
                              input logic [31:0] wd, input bit dedup);
    exp_t e;
    int   k;
    e = '0;
    e.rd0 = rd0;
    e.rd1 = rd1;
    e.lat = 8'(lat);
    e.addr[0] = a0;
    k = 1;
    if (!dedup) begin
      e.addr[1] = a1;
      k = 2;
    end
    if (w != 4'd0) begin
      e.we[k]   = w;
      e.addr[k] = wa;
      e.wd[k]   = wd;
      k++;
    end
    e.nreq = 8'(k);
    return e;
  endfunction

  // Monitor: checks every presented request and every release against the queue head.
  int   bcyc = 0;
  int   reqi = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      bcyc = 0;
      reqi = 0;
    end else begin
      bcyc++;
      if (bus.ram_req && sb.size() > 0) begin
        if (reqi >= int'(sb[0].nreq)) begin
          checks++;
          failures++;
          $display("FAIL extra_request index=%0d actual_addr=%0h required_count=%0d",
                   reqi, bus.ram_addr, sb[0].nreq);
        end else begin
          chk("req_we", 64'(bus.ram_we), 64'(sb[0].we[reqi]));
          chk("req_addr", 64'(bus.ram_addr), 64'(sb[0].addr[reqi]));
          if (sb[0].we[reqi] != 4'd0)
            chk("req_wdata", 64'(bus.ram_wdata), 64'(sb[0].wd[reqi]));
        end
        if (bus.ram_ack) reqi++;
      end
      if (clk_en) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_clk_en actual=1 required=0");
        end else begin
          cur = sb.pop_front();
          chk("rdata0", 64'(rdata0), 64'(cur.rd0));
          chk("rdata1", 64'(rdata1), 64'(cur.rd1));
          chk("latency", 64'(bcyc), 64'(cur.lat));
          chk("request_count", 64'(reqi), 64'(cur.nreq));
        end
        bcyc = 0;
        reqi = 0;
      end
    end
  end

  task automatic drive(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [3:0] w, input logic [ADDR_W-1:0] wa, input logic [31:0] wd);
    raddr0 = a0;
    raddr1 = a1;
    wen    = w;
    waddr  = wa;
    wdata  = wd;
  endtask

  // Returns #1 after the edge that leaves RELEASE, i.e. inside the next CAPTURE cycle.
  task automatic wait_release();
    int n;
    n = 0;
    @(negedge clk);
    while (!clk_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!clk_en) begin
      checks++;
      failures++;
      $display("FAIL release_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit dd;
`ifdef MEM_RESPONDER_DEDUP_EN
    dd = 1'b1;
`else
    dd = 1'b0;
`endif
    drive(18'h10, 18'h20, 4'h0, 18'h3FFFF, 32'h55555555);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_en", 64'(clk_en), 64'd0);
    chk("rst_ram_req", 64'(bus.ram_req), 64'd0);
    chk("rst_ram_we", 64'(bus.ram_we), 64'd0);
    chk("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(bus.ram_wdata), 64'd0);
    chk("rst_rdata0", 64'(rdata0), 64'd0);
    chk("rst_rdata1", 64'(rdata1), 64'd0);

    // Two reads, no write: release in cycle 4.
    sb.push_back(mk(32'hAAAA0001, 32'hBBBB0002, 4, 18'h10, 18'h20, 4'h0, 18'h3FFFF, 32'h0, 1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_release();

    // Reads then a two-byte write: release in cycle 5.
    drive(18'h10, 18'h20, 4'b0011, 18'h30, 32'h12345678);
    sb.push_back(mk(32'hAAAA0001, 32'hBBBB0002, 5, 18'h10, 18'h20, 4'b0011, 18'h30, 32'h12345678, 1'b0));
    wait_release();

    // Only the low two bytes of 0x30 were written.
    drive(18'h30, 18'h10, 4'h0, 18'h30, 32'h0);
    sb.push_back(mk(32'h00005678, 32'hAAAA0001, 4, 18'h30, 18'h10, 4'h0, 18'h0, 32'h0, 1'b0));
    wait_release();

    // Ack delayed by three cycles per request: release in cycle 10.
    delay = 3;
    drive(18'h10, 18'h20, 4'h0, 18'h0, 32'h0);
    sb.push_back(mk(32'hAAAA0001, 32'hBBBB0002, 10, 18'h10, 18'h20, 4'h0, 18'h0, 32'h0, 1'b0));
    wait_release();
    delay = 0;

    // Read of the write address in the same bundle sees the old word.
    drive(18'h10, 18'h40, 4'hF, 18'h40, 32'hFFFFFFFF);
    sb.push_back(mk(32'hAAAA0001, 32'h00000000, 5, 18'h10, 18'h40, 4'hF, 18'h40, 32'hFFFFFFFF, 1'b0));
    wait_release();
    drive(18'h40, 18'h20, 4'h0, 18'h0, 32'h0);
    sb.push_back(mk(32'hFFFFFFFF, 32'hBBBB0002, 4, 18'h40, 18'h20, 4'h0, 18'h0, 32'h0, 1'b0));
    wait_release();

    // Same address on both read ports.
    drive(18'h50, 18'h50, 4'h0, 18'h0, 32'h0);
    sb.push_back(mk(32'hCAFE0050, 32'hCAFE0050, dd ? 3 : 4, 18'h50, 18'h50, 4'h0, 18'h0, 32'h0, dd));
    wait_release();

    // Reset while the write is pending: nothing is written, bundle restarts.
    delay = 4;
    drive(18'h10, 18'h20, 4'hF, 18'h20, 32'hDEADBEEF);
    n = 0;
    @(negedge clk);
    while (bus.ram_we == 4'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr_state", 64'(bus.ram_we), 64'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ram_req", 64'(bus.ram_req), 64'd0);
    chk("async_rst_ram_we", 64'(bus.ram_we), 64'd0);
    chk("async_rst_clk_en", 64'(clk_en), 64'd0);
    chk("async_rst_rdata0", 64'(rdata0), 64'd0);
    chk("async_rst_rdata1", 64'(rdata1), 64'd0);
    delay = 0;
    repeat (2) @(posedge clk);
    chk("aborted_write_word", 64'(ram[8'h20]), 64'hBBBB0002);
    sb.push_back(mk(32'hAAAA0001, 32'hBBBB0002, 5, 18'h10, 18'h20, 4'hF, 18'h20, 32'hDEADBEEF, 1'b0));
    #1 rst_n = 1'b1;
    wait_release();

    drive(18'h20, 18'h10, 4'h0, 18'h0, 32'h0);
    sb.push_back(mk(32'hDEADBEEF, 32'hAAAA0001, 4, 18'h20, 18'h10, 4'h0, 18'h0, 32'h0, 1'b0));
    wait_release();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
